// File: rtl/fetch_fd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared types and constants for the fetch stage and the
//             fetch/decode pipeline register.
//             - NOP_INSTR : bubble encoding handed to decode
//             - OP_HALT   : opcode field value of the halt instruction
//             - fetch_state_e : FETCH / HOLD / HALTED
//             - fd_payload_t  : {instr, pc2, valid} carried into decode
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [4:0]  OP_HALT   = 5'b00000;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc2;
        logic        valid;
    } fd_payload_t;

    // Takes only the opcode field so callers never pass unused operand bits.
    function automatic logic is_halt(input logic [4:0] opcode);
        return (opcode == OP_HALT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fd_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_fd_if
//  Purpose  : Bundles the instruction-memory bus, the decode-side F/D outputs
//             and the control inputs (stall, redirect) of the fetch stage.
//  Modports : master - the fetch stage (drives imem_addr/imem_rd and the F/D
//                      outputs, receives memory data and control inputs)
//             slave  - the environment (memory, decode, branch resolution)
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch_fd_if;

    logic [15:0] imem_addr;
    logic        imem_rd;
    logic [15:0] imem_rdata;
    logic        imem_done;
    logic        stall_fd;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] instr_fd;
    logic [15:0] pc2_fd;
    logic        valid_fd;
    logic        halted;
    logic        err_fetch;

    modport master (
        output imem_addr, imem_rd,
        input  imem_rdata, imem_done,
        input  stall_fd, redirect, redirect_pc,
        output instr_fd, pc2_fd, valid_fd, halted, err_fetch
    );

    modport slave (
        input  imem_addr, imem_rd,
        output imem_rdata, imem_done,
        output stall_fd, redirect, redirect_pc,
        input  instr_fd, pc2_fd, valid_fd, halted, err_fetch
    );

endinterface
`default_nettype wire

// File: rtl/fetch_fd_skid.sv
`default_nettype none
// ============================================================================
//  Module   : fd_skid
//  Purpose  : One-entry skid buffer for a pipeline register payload.
//  Ports    : clk, rst_n   - clock, synchronous active-low reset
//             load         - capture d (entry becomes full)
//             drain        - consumer took q (entry becomes empty)
//             clear        - flush, highest priority
//             d / q        - payload in / stored payload
//             full         - q holds a live entry
//  Revision : 1.0 - initial release
// ============================================================================
module fd_skid
    import fetch_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        load,
    input  wire logic        drain,
    input  wire logic        clear,
    input  wire fd_payload_t d,
    output fd_payload_t      q,
    output logic             full
);

    fd_payload_t data_d, data_q;
    logic        full_d, full_q;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (clear) begin
            full_d = 1'b0;
        end else if (load) begin
            data_d = d;
            full_d = 1'b1;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '{instr: NOP_INSTR, pc2: 16'h0000, valid: 1'b0};
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign q    = data_q;
    assign full = full_q;

endmodule
`default_nettype wire

// File: rtl/fetch_fd.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_fd
//  Purpose  : Instruction-fetch stage plus fetch/decode pipeline register.
//             Holds the PC, drives instruction memory, absorbs decode
//             back-pressure through a one-entry skid buffer, follows
//             redirects and stops fetching after a halt.
//  Ports    : clk    - clock, all state updates on rising edge
//             rst_n  - synchronous active-low reset
//             bus    - fetch_fd_if.master: imem_addr/imem_rd/imem_rdata/
//                      imem_done, stall_fd, redirect/redirect_pc,
//                      instr_fd/pc2_fd/valid_fd, halted, err_fetch
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_fd
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    fetch_fd_if.master     bus
);

    fetch_state_e state_d, state_q;
    logic [15:0]  pc_d, pc_q;
    fd_payload_t  fd_d, fd_q;
    logic         halted_d, halted_q;
    logic         err_d, err_q;

    logic         skid_load, skid_drain, skid_clear, skid_full;
    fd_payload_t  skid_in, skid_q;
    logic [15:0]  pc_plus2;

    // Modulo-2^16: 16'hFFFE + 2 wraps to 16'h0000 silently.
    assign pc_plus2 = pc_q + 16'd2;
    assign skid_in  = '{instr: bus.imem_rdata, pc2: pc_plus2, valid: 1'b1};

    fd_skid u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .drain (skid_drain),
        .clear (skid_clear),
        .d     (skid_in),
        .q     (skid_q),
        .full  (skid_full)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fd_d       = fd_q;
        halted_d   = halted_q;
        err_d      = err_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;

        if (bus.redirect) begin
            // Redirect overrides stall and drops any same-cycle memory data.
            // A bubble keeps the previous pc2 value.
            pc_d       = {bus.redirect_pc[15:1], 1'b0};
            fd_d.instr = NOP_INSTR;
            fd_d.valid = 1'b0;
            skid_clear = 1'b1;
            halted_d   = 1'b0;
            state_d    = FETCH;
            if (bus.redirect_pc[0]) begin
                err_d = 1'b1;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (bus.imem_done) begin
                        pc_d = pc_plus2;
                        if (!bus.stall_fd) begin
                            fd_d = skid_in;
                            if (is_halt(bus.imem_rdata[15:11])) begin
                                state_d  = HALTED;
                                halted_d = 1'b1;
                            end
                        end else begin
                            // Decode is stalled: park the word in the skid.
                            skid_load = 1'b1;
                            state_d   = HOLD;
                        end
                    end else if (!bus.stall_fd) begin
                        fd_d.instr = NOP_INSTR;
                        fd_d.valid = 1'b0;
                    end
                end
                HOLD: begin
                    if (!bus.stall_fd && skid_full) begin
                        fd_d       = skid_q;
                        skid_drain = 1'b1;
                        if (is_halt(skid_q.instr[15:11])) begin
                            state_d  = HALTED;
                            halted_d = 1'b1;
                        end else begin
                            state_d = FETCH;
                        end
                    end else if (!bus.stall_fd) begin
                        state_d = FETCH;
                    end
                end
                HALTED: begin
                    // The halt itself is consumed by decode, then bubbles.
                    if (!bus.stall_fd) begin
                        fd_d.instr = NOP_INSTR;
                        fd_d.valid = 1'b0;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            fd_q     <= '{instr: NOP_INSTR, pc2: 16'h0000, valid: 1'b0};
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            fd_q     <= fd_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.imem_rd   = rst_n && (state_q == FETCH);
    assign bus.instr_fd  = fd_q.instr;
    assign bus.pc2_fd    = fd_q.pc2;
    assign bus.valid_fd  = fd_q.valid;
    assign bus.halted    = halted_q;
    assign bus.err_fetch = err_q;

endmodule
`default_nettype wire

// File: doc/fetch_fd.md
# fetch_fd

Instruction-fetch stage and fetch/decode pipeline register. Holds the PC and drives the instruction memory. Delivers `instr_fd`, the same bus the decode control unit consumes, together with PC+2 and a valid bit. Handles decode back-pressure through a one-entry skid buffer, redirects from branch/jump resolution, and stops fetching after a `halt`.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC loaded at reset
- `NOP_INSTR`, 16'h0800, bubble encoding (opcode 5'b00001)

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `imem_addr`  out  16  fetch address, combinational from PC
- `imem_rd`  out  1  fetch request
- `imem_rdata`  in  16  instruction word, valid when `imem_done`=1
- `imem_done`  in  1  data for current `imem_addr` valid this cycle
- `stall_fd`  in  1  decode cannot accept; F/D register must hold
- `redirect`  in  1  load `redirect_pc`, flush F/D and skid buffer
- `redirect_pc`  in  16  redirect target
- `instr_fd`  out  16  instruction to decode
- `pc2_fd`  out  16  PC+2 of `instr_fd`
- `valid_fd`  out  1  `instr_fd` is a real instruction, not a bubble
- `halted`  out  1  halt delivered to decode; fetch stopped
- `err_fetch`  out  1  sticky odd-redirect error

## Operation
- **States:** FETCH, HOLD, HALTED.
- **Reset** (`rst_n`=0 at edge): pc=`RESET_PC`, `instr_fd`=`NOP_INSTR`, `pc2_fd`=0, `valid_fd`=0, skid buffer empty, `halted`=0, `err_fetch`=0, state=FETCH. `imem_rd`=0 while `rst_n`=0. Reset asserted mid-fetch discards everything.
- **FETCH**
  - `imem_rd`=1, `imem_addr`=pc.
  - On `imem_done` with `stall_fd`=0: F/D ← {`imem_rdata`, pc+2, valid=1} and pc ← pc+2. If `imem_rdata[15:11]`=5'b00000, go to HALTED.
  - On `imem_done` with `stall_fd`=1: skid ← {`imem_rdata`, pc+2}, pc ← pc+2, go to HOLD. The F/D register holds.
  - With no `imem_done` and `stall_fd`=0: F/D ← bubble (`NOP_INSTR`, valid=0). `pc2_fd` holds its old value.
- **HOLD**
  - `imem_rd`=0.
  - While `stall_fd`=1: everything holds.
  - When `stall_fd`=0: F/D ← skid and the skid empties. Go to HALTED if the skid opcode is halt, else to FETCH.
- **HALTED**
  - `imem_rd`=0 and `halted`=1. F/D becomes a bubble once `stall_fd`=0.
  - Exit only via `redirect` (wrong-path halt) or reset.
- **Redirect** (highest priority, any state; wins over `stall_fd` and a same-cycle `imem_done`, whose data is dropped):
  - pc ← {`redirect_pc[15:1]`,1'b0}.
  - F/D ← bubble; skid cleared; `halted` ← 0; state ← FETCH.
- **Odd target:** if `redirect_pc[0]`=1, `err_fetch` ← 1 and stays 1 until reset.
- **PC arithmetic:** 16-bit modulo, so 16'hFFFE+2 = 16'h0000 with no flag.
- **Memory contract:** `imem_done` refers only to the address presented in that cycle. The memory keeps no state across an address change.

## Timing
- Throughput is 1 instruction/cycle when `imem_done` returns in the same cycle as the request.
- Fetch-to-decode latency is 1 edge after `imem_done`.
- Redirect asserted at edge N means `imem_addr`=target during cycle N+1. With zero-wait memory, the first `valid_fd` is visible after edge N+1.
- Stall release: skid contents appear on `instr_fd` after the first edge with `stall_fd`=0. No instruction is lost or duplicated.
- `halted` rises at the same edge that loads the halt instruction into F/D.

## Structure
- **Shared package `fetch_pkg`:**
  - `NOP_INSTR` and `OP_HALT` (5'b00000)
  - state enum {FETCH, HOLD, HALTED}
  - F/D payload struct {instr[15:0], pc2[15:0], valid}
- **Sub-module `fd_skid`:** one-entry skid buffer with load, drain, clear and full; reused by later pipeline registers.

## Test plan
- **Sequential fetch:** reset, then `imem_done`=1 constantly, with the memory returning `addr|16'h4000` → `instr_fd` = 16'h4000, 16'h4002, 16'h4004 on consecutive cycles; `pc2_fd` = 2, 4, 6.
- **Stall with done:** `stall_fd`=1 for 3 cycles while the instruction at 0x0004 returns → `instr_fd` holds the 0x0002 word. `imem_rd`=0 during HOLD. After release, the 0x0004 word appears exactly once, then fetch resumes at 0x0006.
- **Redirect priority:** `redirect`=1 to 0x0100 together with `stall_fd`=1 and `imem_done`=1 → the next cycle shows `valid_fd`=0 and `imem_addr`=0x0100; the dropped word never reaches decode.
- **Halt:** the memory returns 16'h0000 at 0x0008 → `halted`=1 and `imem_rd`=0 thereafter. A `redirect` to 0x0020 clears `halted` and fetching resumes.
- **Odd redirect and wrap:** `redirect_pc`=0x0101 → `err_fetch`=1 (sticky) and `imem_addr`=0x0100. `redirect_pc`=0xFFFE → the next fetch address is 0x0000.
- **Reset mid-stall:** HOLD with the skid full, then `rst_n`=0 for one edge → all outputs return to their reset values and the skid word is never delivered.
